// File: rtl/mult18_seq_ctrl.sv
// Sequential 18x18 multiplier controller driving a shared 9x9 multiplier.
// Define MULT18_SEQ_CTRL_PIPE_EN to register mul_C before accumulation.
module mult18_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic        a_signed,
    input  logic        b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] p,
    output logic [8:0]  mul_A,
    output logic [8:0]  mul_B,
    output logic        mul_A_sign,
    output logic        mul_B_sign,
    output logic        mul_HALF_0,
    input  logic [17:0] mul_C
);

    typedef enum logic [2:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [17:0] a_q;
    logic [17:0] b_q;
    logic        as_q;
    logic        bs_q;
    logic [35:0] acc;
    logic [35:0] c_ext;
    logic [35:0] term;
    logic [4:0]  sh;

    assign mul_HALF_0 = 1'b1;

    // Any signed operand makes the 18-bit partial product two's complement.
    assign c_ext = (mul_A_sign | mul_B_sign) ? {{18{mul_C[17]}}, mul_C}
                                             : {18'd0, mul_C};

    always_comb begin
        sh = 5'd0;
        case (state)
            PP1, PP2: sh = 5'd9;
            PP3:      sh = 5'd18;
            default:  sh = 5'd0;
        endcase
    end

    assign term = c_ext << sh;

`ifdef MULT18_SEQ_CTRL_PIPE_EN
    logic [35:0] term_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= 18'd0;
            b_q        <= 18'd0;
            as_q       <= 1'b0;
            bs_q       <= 1'b0;
            acc        <= 36'd0;
            p          <= 36'd0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            mul_A      <= 9'd0;
            mul_B      <= 9'd0;
            mul_A_sign <= 1'b0;
            mul_B_sign <= 1'b0;
`ifdef MULT18_SEQ_CTRL_PIPE_EN
            term_q     <= 36'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q        <= a;
                        b_q        <= b;
                        as_q       <= a_signed;
                        bs_q       <= b_signed;
                        acc        <= 36'd0;
                        in_ready   <= 1'b0;
                        mul_A      <= a[8:0];
                        mul_B      <= b[8:0];
                        mul_A_sign <= 1'b0;
                        mul_B_sign <= 1'b0;
                        state      <= PP0;
                    end
                end
                PP0: begin
`ifdef MULT18_SEQ_CTRL_PIPE_EN
                    term_q     <= term;
`else
                    acc        <= acc + term;
`endif
                    mul_A      <= a_q[8:0];
                    mul_B      <= b_q[17:9];
                    mul_A_sign <= 1'b0;
                    mul_B_sign <= bs_q;
                    state      <= PP1;
                end
                PP1: begin
`ifdef MULT18_SEQ_CTRL_PIPE_EN
                    term_q     <= term;
                    acc        <= acc + term_q;
`else
                    acc        <= acc + term;
`endif
                    mul_A      <= a_q[17:9];
                    mul_B      <= b_q[8:0];
                    mul_A_sign <= as_q;
                    mul_B_sign <= 1'b0;
                    state      <= PP2;
                end
                PP2: begin
`ifdef MULT18_SEQ_CTRL_PIPE_EN
                    term_q     <= term;
                    acc        <= acc + term_q;
`else
                    acc        <= acc + term;
`endif
                    mul_A      <= a_q[17:9];
                    mul_B      <= b_q[17:9];
                    mul_A_sign <= as_q;
                    mul_B_sign <= bs_q;
                    state      <= PP3;
                end
                PP3: begin
                    mul_A      <= 9'd0;
                    mul_B      <= 9'd0;
                    mul_A_sign <= 1'b0;
                    mul_B_sign <= 1'b0;
`ifdef MULT18_SEQ_CTRL_PIPE_EN
                    term_q     <= term;
                    acc        <= acc + term_q;
                    state      <= WAIT;
`else
                    p          <= acc + term;
                    out_valid  <= 1'b1;
                    state      <= DONE;
`endif
                end
`ifdef MULT18_SEQ_CTRL_PIPE_EN
                WAIT: begin
                    p          <= acc + term_q;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult18_seq_ctrl.sv
// Directed and random checks for mult18_seq_ctrl with a behavioural 9x9 multiplier.
module tb_mult18_seq_ctrl;

`ifdef MULT18_SEQ_CTRL_PIPE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif
    localparam int PERIOD = LAT + 1;
    localparam int N_RAND = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic        a_signed = 1'b0;
    logic        b_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] p;
    logic [8:0]  mul_A;
    logic [8:0]  mul_B;
    logic        mul_A_sign;
    logic        mul_B_sign;
    logic        mul_HALF_0;
    logic [17:0] mul_C;

    int n_checks = 0;
    int n_pass = 0;

    mult18_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .a_signed   (a_signed),
        .b_signed   (b_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p),
        .mul_A      (mul_A),
        .mul_B      (mul_B),
        .mul_A_sign (mul_A_sign),
        .mul_B_sign (mul_B_sign),
        .mul_HALF_0 (mul_HALF_0),
        .mul_C      (mul_C)
    );

    always #5 clk = ~clk;

    logic signed [9:0]  ma;
    logic signed [9:0]  mb;
    logic signed [19:0] mprod;

    always_comb begin
        ma    = mul_A_sign ? {mul_A[8], mul_A} : {1'b0, mul_A};
        mb    = mul_B_sign ? {mul_B[8], mul_B} : {1'b0, mul_B};
        mprod = ma * mb;
        mul_C = mprod[17:0];
    end

    function automatic logic [35:0] ref_mul(input logic [17:0] x, input logic [17:0] y,
                                            input logic xs, input logic ys);
        longint sx;
        longint sy;
        longint r;
        sx = {{46{xs & x[17]}}, x};
        sy = {{46{ys & y[17]}}, y};
        r  = sx * sy;
        return r[35:0];
    endfunction

    // lat counts rising edges, the accept edge being edge 1.
    task automatic do_op(input logic [17:0] ta, input logic [17:0] tb,
                         input logic tas, input logic tbs, input bit rel,
                         output logic [35:0] res, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        a_signed = tas;
        b_signed = tbs;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        a = 18'($urandom);
        b = 18'($urandom);
        a_signed = 1'($urandom);
        b_signed = 1'($urandom);
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        res = p;
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (p !== 36'd0) $display("FAIL reset_p: got %h want 0", p);
        else n_pass++;
        n_checks++;
        if (mul_A !== 9'd0 || mul_B !== 9'd0 || mul_A_sign !== 1'b0 || mul_B_sign !== 1'b0)
            $display("FAIL reset_mul: got %h %h %b %b want 0 0 0 0",
                     mul_A, mul_B, mul_A_sign, mul_B_sign);
        else n_pass++;
        n_checks++;
        if (mul_HALF_0 !== 1'b1) $display("FAIL half_0: got %b want 1", mul_HALF_0);
        else n_pass++;
    endtask

    task automatic test_unsigned_max;
        logic [35:0] res;
        int lat;
        do_op(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== 36'hFFFF80001) $display("FAIL umax_p: got %h want FFFF80001", res);
        else n_pass++;
        n_checks++;
        if (lat != LAT) $display("FAIL umax_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (mul_A !== 9'd0 || mul_B !== 9'd0 || mul_A_sign !== 1'b0 || mul_B_sign !== 1'b0)
            $display("FAIL done_mul: got %h %h %b %b want 0 0 0 0",
                     mul_A, mul_B, mul_A_sign, mul_B_sign);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL done_in_ready: got %b want 0", in_ready);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_signed;
        logic [35:0] res;
        int lat;
        do_op(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1, res, lat);
        n_checks++;
        if (res !== 36'h400000000) $display("FAIL smin_p: got %h want 400000000", res);
        else n_pass++;
        do_op(18'h3FFFF, 18'd5, 1'b1, 1'b1, 1'b1, res, lat);
        n_checks++;
        if (res !== 36'hFFFFFFFFB) $display("FAIL neg1x5_p: got %h want FFFFFFFFB", res);
        else n_pass++;
        do_op(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== 36'hFFFFC0001) $display("FAIL mixed_p: got %h want FFFFC0001", res);
        else n_pass++;
        n_checks++;
        if (lat != LAT) $display("FAIL mixed_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [35:0] res;
        int lat;
        do_op(18'd100, 18'd200, 1'b0, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== 36'd20000) $display("FAIL bp_p: got %0d want 20000", res);
        else n_pass++;
        @(negedge clk);
        a = 18'd3;
        b = 18'd4;
        a_signed = 1'b0;
        b_signed = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || p !== 36'd20000 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b p=%0d r=%b want v=1 p=20000 r=0",
                         i, out_valid, p, in_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_accept: got %b want 0", in_ready);
        else n_pass++;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        n_checks++;
        if (out_valid !== 1'b1 || p !== 36'd12)
            $display("FAIL bp_next_p: got v=%b p=%0d want v=1 p=12", out_valid, p);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [35:0] res;
        int lat;
        bit seen;
        @(negedge clk);
        a = 18'h12345;
        b = 18'h23456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || p !== 36'd0 || in_ready !== 1'b1)
            $display("FAIL midreset_state: got v=%b p=%h r=%b want v=0 p=0 r=1",
                     out_valid, p, in_ready);
        else n_pass++;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midreset_no_valid: got out_valid=1 want 0");
        else n_pass++;
        do_op(18'd7, 18'd9, 1'b0, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== 36'd63) $display("FAIL midreset_next_p: got %0d want 63", res);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int rise_t[3];
        int nr;
        nr = 0;
        @(negedge clk);
        a = 18'd1000;
        b = 18'd3;
        a_signed = 1'b0;
        b_signed = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                rise_t[nr] = c;
                nr++;
                n_checks++;
                if (p !== 36'd3000) $display("FAIL b2b_p: got %0d want 3000", p);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (nr != 3) $display("FAIL b2b_count: got %0d results want 3", nr);
        else n_pass++;
        if (nr == 3) begin
            n_checks++;
            if (rise_t[1] - rise_t[0] != PERIOD || rise_t[2] - rise_t[1] != PERIOD)
                $display("FAIL b2b_period: got %0d,%0d want %0d",
                         rise_t[1] - rise_t[0], rise_t[2] - rise_t[1], PERIOD);
            else n_pass++;
        end
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [35:0] res;
        logic [35:0] exp;
        logic [17:0] ra;
        logic [17:0] rb;
        int lat;
        int bad;
        for (int sc = 0; sc < 4; sc++) begin
            bad = 0;
            for (int i = 0; i < N_RAND; i++) begin
                ra = 18'($urandom);
                rb = 18'($urandom);
                exp = ref_mul(ra, rb, sc[1], sc[0]);
                do_op(ra, rb, sc[1], sc[0], 1'b1, res, lat);
                n_checks++;
                if (res !== exp || lat != LAT) begin
                    if (bad < 5)
                        $display("FAIL rand_s%0d: a=%h b=%h got %h lat %0d want %h lat %0d",
                                 sc, ra, rb, res, lat, exp, LAT);
                    bad++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
